dvr_fifo: RTL and testbench

Parametrised DVR-handshake FIFO that decouples a DVR producer from a DVR consumer, such as between AES pipeline stages. Both sides are dvr_if (data/valid/rdy); a transfer occurs on any cycle with valid && rdy high. Adds configurable depth, fill-level status, almost-full/empty flags and synchronous flush, none of which the bare interface provides.

---
 rtl/dvr_fifo_if.sv | 12 +
 rtl/dvr_fifo.sv | 80 ++++++++
 tb/tb_dvr_fifo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dvr_fifo_if.sv
// dvr_if: data/valid/rdy handshake bundle.
// A transfer completes on any rising edge where valid && rdy.
interface dvr_if #(
   parameter int DW = 256
);
   logic [DW-1:0] data;
   logic          valid;
   logic          rdy;

   modport master (output data, output valid, input rdy);
   modport slave  (input data, input valid, output rdy);
endinterface

// File: rtl/dvr_fifo.sv
// dvr_fifo: DVR-handshake FIFO with fill level, almost flags and flush.
// Define DVR_FIFO_BYPASS_EN for a 0-cycle pass-through when empty.
module dvr_fifo #(
   parameter int DATA_WIDTH_IN_BYTES = 32,
   parameter int DEPTH               = 4,
   parameter int ALMOST_FULL_THRESH  = DEPTH - 1,
   parameter int ALMOST_EMPTY_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   dvr_if.slave                       msg_in,
   dvr_if.master                      msg_out,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty
);
   localparam int DW = DATA_WIDTH_IN_BYTES * 8;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          bypass;
   logic          push;
   logic          pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

`ifdef DVR_FIFO_BYPASS_EN
   assign bypass = empty && !flush && !rst && msg_out.rdy;
`else
   assign bypass = 1'b0;
`endif

   // rdy never looks at msg_out.rdy outside the bypass path
   assign msg_in.rdy    = !rst && !full && !flush;
   assign msg_out.valid = bypass ? msg_in.valid : (!empty && !flush);
   assign msg_out.data  = bypass ? msg_in.data : mem[rd_ptr];

   assign push = msg_in.valid && msg_in.rdy && !bypass;
   assign pop  = msg_out.valid && msg_out.rdy && !bypass;

   assign almost_full  = (count >= CW'(ALMOST_FULL_THRESH));
   assign almost_empty = (count <= CW'(ALMOST_EMPTY_THRESH));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= msg_in.data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_dvr_fifo.sv
// Scoreboard bench for dvr_fifo (DEPTH=4, 4-byte words).
// Input handshakes feed an expected queue; an output monitor pops and compares.
module tb_dvr_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          almost_empty;

   dvr_if #(.DW(DW)) in_if ();
   dvr_if #(.DW(DW)) out_if ();

   dvr_fifo #(
      .DATA_WIDTH_IN_BYTES(4),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .msg_in(in_if),
      .msg_out(out_if),
      .flush(flush),
      .count(count),
      .almost_full(almost_full),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_rx  = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: capture accepted inputs, compare every output transfer
   always @(negedge clk) begin
      if (!rst) begin
         if (in_if.valid && in_if.rdy) begin
            exp_q.push_back(in_if.data);
         end
         if (out_if.valid && out_if.rdy) begin
            n_rx++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL out_unexpected: got %h expected none at %0t",
                        out_if.data, $time);
            end else begin
               check("out_data", out_if.data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] w [4];
      int rx0;
      w[0] = 32'h11111111;
      w[1] = 32'h22222222;
      w[2] = 32'h33333333;
      w[3] = 32'h44444444;
      rst          = 1'b1;
      flush        = 1'b0;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.rdy   = 1'b0;

      // reset state
      step();
      step();
      @(negedge clk);
      check("rst_count", 32'(count), 0);
      check("rst_aempty", 32'(almost_empty), 1);
      check("rst_afull", 32'(almost_full), 0);
      check("rst_valid", 32'(out_if.valid), 0);
      check("rst_in_rdy", 32'(in_if.rdy), 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_rdy", 32'(in_if.rdy), 1);

      // fill to full with consumer stalled
      step();
      for (int i = 0; i < 4; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = w[i];
         @(negedge clk);
         check("fill_in_rdy", 32'(in_if.rdy), 1);
         step();
         check("fill_count", 32'(count), 32'(i + 1));
         check("fill_afull", 32'(almost_full), (i >= 2) ? 1 : 0);
         check("fill_aempty", 32'(almost_empty), (i == 0) ? 1 : 0);
      end

      // full: pop one, push blocked this cycle, accepted next
      in_if.data = 32'h55555555;
      out_if.rdy = 1'b1;
      @(negedge clk);
      check("full_in_rdy", 32'(in_if.rdy), 0);
      check("full_head", out_if.data, 32'h11111111);
      step();
      out_if.rdy = 1'b0;
      check("full_pop_count", 32'(count), 3);
      @(negedge clk);
      check("freed_in_rdy", 32'(in_if.rdy), 1);
      step();
      in_if.valid = 1'b0;
      check("refill_count", 32'(count), 4);
      @(negedge clk);
      check("stall_valid", 32'(out_if.valid), 1);
      check("stall_data", out_if.data, 32'h22222222);

      // drain
      step();
      rx0 = n_rx;
      out_if.rdy = 1'b1;
      repeat (4) step();
      check("drain_rx", 32'(n_rx - rx0), 4);
      check("drain_count", 32'(count), 0);
      check("drain_aempty", 32'(almost_empty), 1);

      // streaming 0..15
      rx0 = n_rx;
      for (int i = 0; i < 16; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = 32'(i);
         @(negedge clk);
`ifdef DVR_FIFO_BYPASS_EN
         check("stream_count", 32'(count), 0);
         check("stream_valid", 32'(out_if.valid), 1);
`else
         check("stream_count", 32'(count), (i == 0) ? 0 : 1);
         check("stream_valid", 32'(out_if.valid), (i == 0) ? 0 : 1);
`endif
         step();
      end
      in_if.valid = 1'b0;
      step();
      check("stream_rx", 32'(n_rx - rx0), 16);
      check("stream_end_count", 32'(count), 0);

      // flush with 3 stored words
      out_if.rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = 32'hA0 + 32'(i);
         step();
      end
      check("pre_flush_count", 32'(count), 3);
      flush       = 1'b1;
      in_if.data  = 32'hDEADBEEF;
      out_if.rdy  = 1'b1;
      @(negedge clk);
      check("flush_in_rdy", 32'(in_if.rdy), 0);
      check("flush_valid", 32'(out_if.valid), 0);
      step();
      flush       = 1'b0;
      in_if.valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("post_flush_count", 32'(count), 0);
      check("post_flush_valid", 32'(out_if.valid), 0);
      check("post_flush_aempty", 32'(almost_empty), 1);

      // async reset with 2 stored words
      step();
      out_if.rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = 32'hB1 + 32'(i);
         step();
      end
      in_if.valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_if.valid), 0);
      check("arst_count", 32'(count), 0);
      step();
      rst = 1'b0;
      exp_q.delete();
      out_if.rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_arst_valid", 32'(out_if.valid), 0);
         step();
      end

      // single word latency
      in_if.valid = 1'b1;
      in_if.data  = 32'hA5A5A5A5;
      @(negedge clk);
`ifdef DVR_FIFO_BYPASS_EN
      check("lat_valid_n", 32'(out_if.valid), 1);
      check("lat_data_n", out_if.data, 32'hA5A5A5A5);
      check("lat_count_n", 32'(count), 0);
`else
      check("lat_valid_n", 32'(out_if.valid), 0);
`endif
      step();
      in_if.valid = 1'b0;
      @(negedge clk);
`ifdef DVR_FIFO_BYPASS_EN
      check("lat_valid_n1", 32'(out_if.valid), 0);
      check("lat_count_n1", 32'(count), 0);
`else
      check("lat_valid_n1", 32'(out_if.valid), 1);
      check("lat_data_n1", out_if.data, 32'hA5A5A5A5);
      check("lat_count_n1", 32'(count), 1);
`endif
      step();
      step();
      check("final_count", 32'(count), 0);
      check("sb_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
